tx_interpolator: RTL and testbench

- Transmit-direction counterpart of the receiver decimation chain: accepts baseband I/Q samples at the low rate through a valid/ready handshake.
- Interpolates each channel by INTERPOLATION with a STAGES-order CIC interpolator and delivers one I/Q sample per clock at 122.88 MHz.
- Sits between the host sample source and the upconverter/DAC path.
- Owns a one-entry input buffer, the rate counter, and underflow detection.

---
 rtl/tx_interpolator.sv | 136 +++++++++++++
 tb/tb_tx_interpolator.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/tx_interpolator.sv
`default_nettype none
// ============================================================================
// Module   : tx_interpolator
// Purpose  : Transmit-side I/Q interpolator. Low-rate baseband samples enter
//            through a one-entry valid/ready buffer. Each channel is then
//            interpolated by INTERPOLATION using a STAGES-order CIC filter:
//            low-rate combs, zero stuffing, full-rate integrators. One I/Q
//            sample leaves on every clock.
// Ports    : clock, reset          - system clock, sync active-high reset
//            in_valid/in_ready     - input handshake
//            in_data_I/in_data_Q   - signed low-rate samples (IN_WIDTH)
//            sample_tick           - pulse when a low-rate slot is consumed
//            underflow             - pulse when a slot found the buffer empty
//            out_data_I/out_data_Q - signed full-rate outputs (OUT_WIDTH)
// Revision : 1.0 - initial release
// ============================================================================
module tx_interpolator #(
    parameter int STAGES        = 5,
    parameter int INTERPOLATION = 250,
    parameter int IN_WIDTH      = 24,
    parameter int OUT_WIDTH     = 16,
    parameter int ACC_WIDTH     = 56
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [IN_WIDTH-1:0]  in_data_I,
    input  logic signed [IN_WIDTH-1:0]  in_data_Q,
    output logic                        sample_tick,
    output logic                        underflow,
    output logic signed [OUT_WIDTH-1:0] out_data_I,
    output logic signed [OUT_WIDTH-1:0] out_data_Q
);

    localparam int             CNT_W    = $clog2(INTERPOLATION);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INTERPOLATION - 1);

    // Rate counter and handshake state
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             full_q, full_d;
    logic             sample_tick_q, sample_tick_d;
    logic             underflow_q, underflow_d;
    logic             tick;
    logic             xfer;

    // Per-channel state, index 0 = I, 1 = Q
    logic signed [IN_WIDTH-1:0]  hold_q     [2];
    logic signed [IN_WIDTH-1:0]  hold_d     [2];
    logic signed [ACC_WIDTH-1:0] dly_q      [2][STAGES];
    logic signed [ACC_WIDTH-1:0] dly_d      [2][STAGES];
    logic signed [ACC_WIDTH-1:0] comb_out_q [2];
    logic signed [ACC_WIDTH-1:0] comb_out_d [2];
    logic signed [ACC_WIDTH-1:0] integ_q    [2][STAGES];
    logic signed [ACC_WIDTH-1:0] integ_d    [2][STAGES];
    logic signed [OUT_WIDTH-1:0] out_q      [2];
    logic signed [OUT_WIDTH-1:0] out_d      [2];
    logic signed [ACC_WIDTH-1:0] comb_c     [2][STAGES+1];
    logic signed [ACC_WIDTH-1:0] zstuff     [2];

    always_comb begin
        tick     = (cnt_q == CNT_LAST);
        in_ready = !reset && (!full_q || tick);
        xfer     = in_valid && in_ready;

        cnt_d         = tick ? '0 : cnt_q + 1'b1;
        sample_tick_d = tick;
        underflow_d   = tick && !full_q;

        // A tick empties the buffer; a same-cycle transfer refills it
        full_d = full_q;
        if (tick) full_d = 1'b0;
        if (xfer) full_d = 1'b1;

        hold_d[0] = xfer ? in_data_I : hold_q[0];
        hold_d[1] = xfer ? in_data_Q : hold_q[1];

        for (int ch = 0; ch < 2; ch++) begin
            // Empty buffer on a tick feeds a zero sample into the combs
            comb_c[ch][0] = full_q ?
                {{(ACC_WIDTH-IN_WIDTH){hold_q[ch][IN_WIDTH-1]}}, hold_q[ch]} : '0;
            for (int k = 0; k < STAGES; k++) begin
                comb_c[ch][k+1] = comb_c[ch][k] - dly_q[ch][k];
                dly_d[ch][k]    = tick ? comb_c[ch][k] : dly_q[ch][k];
            end
            comb_out_d[ch] = tick ? comb_c[ch][STAGES] : comb_out_q[ch];

            // Comb output enters the integrators only on the clock after tick
            zstuff[ch]      = sample_tick_q ? comb_out_q[ch] : '0;
            integ_d[ch][0]  = integ_q[ch][0] + zstuff[ch];
            for (int k = 1; k < STAGES; k++) begin
                integ_d[ch][k] = integ_q[ch][k] + integ_q[ch][k-1];
            end
            out_d[ch] = integ_q[ch][STAGES-1][ACC_WIDTH-1 -: OUT_WIDTH];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q         <= '0;
            full_q        <= 1'b0;
            sample_tick_q <= 1'b0;
            underflow_q   <= 1'b0;
            for (int ch = 0; ch < 2; ch++) begin
                hold_q[ch]     <= '0;
                comb_out_q[ch] <= '0;
                out_q[ch]      <= '0;
                for (int k = 0; k < STAGES; k++) begin
                    dly_q[ch][k]   <= '0;
                    integ_q[ch][k] <= '0;
                end
            end
        end else begin
            cnt_q         <= cnt_d;
            full_q        <= full_d;
            sample_tick_q <= sample_tick_d;
            underflow_q   <= underflow_d;
            for (int ch = 0; ch < 2; ch++) begin
                hold_q[ch]     <= hold_d[ch];
                comb_out_q[ch] <= comb_out_d[ch];
                out_q[ch]      <= out_d[ch];
                for (int k = 0; k < STAGES; k++) begin
                    dly_q[ch][k]   <= dly_d[ch][k];
                    integ_q[ch][k] <= integ_d[ch][k];
                end
            end
        end
    end

    assign sample_tick = sample_tick_q;
    assign underflow   = underflow_q;
    assign out_data_I  = out_q[0];
    assign out_data_Q  = out_q[1];

endmodule
`default_nettype wire

// File: tb/tb_tx_interpolator.sv
`default_nettype none
// ============================================================================
// Module   : tb_tx_interpolator
// Purpose  : Self-checking bench for tx_interpolator. A small instance
//            (N=3, R=4, 20-bit accumulators) covers DC, underflow, reset
//            mid-run and the impulse/handshake table. A default-parameter
//            instance covers full-scale DC with accumulator wrap-around.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tx_interpolator;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // Small instance
    logic               reset_s, valid_s, ready_s, stick_s, uf_s;
    logic signed [15:0] di_s, dq_s, oi_s, oq_s;

    tx_interpolator #(
        .STAGES(3), .INTERPOLATION(4), .IN_WIDTH(16), .OUT_WIDTH(16), .ACC_WIDTH(20)
    ) u_small (
        .clock(clock), .reset(reset_s), .in_valid(valid_s), .in_ready(ready_s),
        .in_data_I(di_s), .in_data_Q(dq_s), .sample_tick(stick_s),
        .underflow(uf_s), .out_data_I(oi_s), .out_data_Q(oq_s)
    );

    // Default-parameter instance
    logic               reset_b, valid_b, ready_b, stick_b, uf_b;
    logic signed [23:0] di_b, dq_b;
    logic signed [15:0] oi_b, oq_b;

    tx_interpolator u_big (
        .clock(clock), .reset(reset_b), .in_valid(valid_b), .in_ready(ready_b),
        .in_data_I(di_b), .in_data_Q(dq_b), .sample_tick(stick_b),
        .underflow(uf_b), .out_data_I(oi_b), .out_data_Q(oq_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // CIC N=3 R=4 impulse response, (1+z^-1+z^-2+z^-3)^3
    int h [10] = '{1, 3, 6, 10, 12, 12, 10, 6, 3, 1};

    typedef struct {
        logic valid;
        int   di;
        int   dq;
        logic exp_ready;
        logic exp_stick;
        logic exp_uf;
        int   exp_i;
        int   exp_q;
    } vec_t;

    vec_t tbl [24];

    task automatic check(input string name, input int cyc, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Expected output for the DC/underflow run: slot j is consumed on tick
    // cycle 4j+3 and reaches the output 5 clocks later, weighted by h and
    // divided by the gain R^(N-1)=16 with floor truncation. Slots 11 and 12
    // find the buffer empty and contribute zero.
    function automatic int conv_exp(input int n, input int amp);
        int s = 0;
        for (int j = 0; j < 20; j++) begin
            int k = n - 8 - 4 * j;
            if (k >= 0 && k < 10 && j != 11 && j != 12) s += amp * h[k];
        end
        return s >>> 4;
    endfunction

    initial begin
        int prev_i, prev_q;

        reset_s = 1'b1; valid_s = 1'b0; di_s = '0; dq_s = '0;
        reset_b = 1'b1; valid_b = 1'b0; di_b = '0; dq_b = '0;

        // Reset state
        repeat (3) @(negedge clock);
        valid_s = 1'b1;
        #1;
        check("rst_ready", 0, int'(ready_s), 0);
        check("rst_stick", 0, int'(stick_s), 0);
        check("rst_uf",    0, int'(uf_s),    0);
        check("rst_out_i", 0, int'(oi_s),    0);
        check("rst_out_q", 0, int'(oq_s),    0);

        // DC 1000/-1000, valid dropped for cycles 40..50 so ticks 47 and 51
        // find the buffer empty; the transfer on tick 51 is used on tick 55.
        for (int n = 0; n < 73; n++) begin
            @(negedge clock);
            reset_s = 1'b0;
            valid_s = (n < 40 || n >= 51);
            di_s    = 16'sd1000;
            dq_s    = -16'sd1000;
            #1;
            check("dc_ready", n, int'(ready_s),
                  int'(n == 0 || (n >= 43 && n <= 51) || (n % 4 == 3)));
            check("dc_stick", n, int'(stick_s), int'(n > 0 && n % 4 == 0));
            check("dc_uf",    n, int'(uf_s),    int'(n == 48 || n == 52));
            check("dc_out_i", n, int'(oi_s),    conv_exp(n, 1000));
            check("dc_out_q", n, int'(oq_s),    conv_exp(n, -1000));
        end

        // One-clock reset during the nonzero output
        @(negedge clock);
        reset_s = 1'b1;
        #1;
        check("midrst_ready", 73, int'(ready_s), 0);
        check("midrst_out_i", 73, int'(oi_s), conv_exp(73, 1000));

        // Impulse / handshake table after the restart
        for (int n = 0; n < 24; n++) begin
            tbl[n].valid     = 1'b1;
            tbl[n].di        = (n == 0) ? 16 : 0;
            tbl[n].dq        = (n == 0) ? -16 : 0;
            tbl[n].exp_ready = (n == 0) || (n % 4 == 3);
            tbl[n].exp_stick = (n > 0) && (n % 4 == 0);
            tbl[n].exp_uf    = 1'b0;
            tbl[n].exp_i     = (n >= 8 && n < 18) ? h[n-8] : 0;
            tbl[n].exp_q     = -tbl[n].exp_i;
        end
        for (int n = 0; n < 24; n++) begin
            @(negedge clock);
            reset_s = 1'b0;
            valid_s = tbl[n].valid;
            di_s    = 16'(tbl[n].di);
            dq_s    = 16'(tbl[n].dq);
            #1;
            check("imp_ready", n, int'(ready_s), int'(tbl[n].exp_ready));
            check("imp_stick", n, int'(stick_s), int'(tbl[n].exp_stick));
            check("imp_uf",    n, int'(uf_s),    int'(tbl[n].exp_uf));
            check("imp_out_i", n, int'(oi_s),    tbl[n].exp_i);
            check("imp_out_q", n, int'(oq_s),    tbl[n].exp_q);
        end

        // Full-scale DC on the default instance. Gain 250^4 = 2^4*5^12, so
        // I: floor(8388607*250^4/2^40) = 29802, Q: floor(-2^23*250^4/2^40) = -29803.
        // All coefficients are positive, so the step response is monotonic.
        prev_i = 0;
        prev_q = 0;
        for (int n = 0; n < 10000; n++) begin
            @(negedge clock);
            reset_b = 1'b0;
            valid_b = 1'b1;
            di_b    = 24'sd8388607;
            dq_b    = -24'sd8388608;
            #1;
            check("wrap_uf",     n, int'(uf_b), 0);
            check("wrap_mono_i", n, int'(int'(oi_b) >= prev_i), 1);
            check("wrap_mono_q", n, int'(int'(oq_b) <= prev_q), 1);
            if (n >= 8000) begin
                check("wrap_dc_i", n, int'(oi_b), 29802);
                check("wrap_dc_q", n, int'(oq_b), -29803);
            end
            prev_i = int'(oi_b);
            prev_q = int'(oq_b);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
